// File: rtl/ysyx_22051013_regfile_sb_pkg.sv
// Shared defines for the regfile/scoreboard slice.
// Widths, zero constant and polarity constants.
package ysyx_22051013_regfile_sb_pkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;

   localparam logic [63:0] ZERO64 = 64'h0;

   localparam logic RST_ACTIVE = 1'b1;
   localparam logic EN_ACTIVE  = 1'b1;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_DEC  = 2'b01,
      CNT_INC  = 2'b10,
      CNT_BOTH = 2'b11
   } cnt_op_e;

   function automatic logic is_on(input logic s);
      return s == EN_ACTIVE;
   endfunction

endpackage

// File: rtl/ysyx_22051013_regfile_sb_if.sv
// Writeback, read, issue and scoreboard status bundle.
// master drives requests, slave is the regfile.
interface ysyx_22051013_regfile_sb_if #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
);

   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;
   logic            wen;

   logic [AW-1:0]   raddr1;
   logic [AW-1:0]   raddr2;
   logic            ren1;
   logic            ren2;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;

   logic            busy_set;
   logic [AW-1:0]   busy_addr;
   logic            hazard1;
   logic            hazard2;
   logic [NREG-1:0] busy_vec;
   logic [AW:0]     busy_cnt;

   modport master (
      output waddr, wdata, wen,
      output raddr1, raddr2, ren1, ren2,
      output busy_set, busy_addr,
      input  rdata1, rdata2,
      input  hazard1, hazard2,
      input  busy_vec, busy_cnt
   );

   modport slave (
      input  waddr, wdata, wen,
      input  raddr1, raddr2, ren1, ren2,
      input  busy_set, busy_addr,
      output rdata1, rdata2,
      output hazard1, hazard2,
      output busy_vec, busy_cnt
   );

endinterface

// File: rtl/ysyx_22051013_scoreboard.sv
// Pending-destination bits with a registered population count.
// A set and a clear to the same register in one cycle leaves it set.
module ysyx_22051013_scoreboard
   import ysyx_22051013_regfile_sb_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set,
   input  logic [AW-1:0]   set_addr,
   input  logic            clr,
   input  logic [AW-1:0]   clr_addr,
   output logic [NREG-1:0] busy,
   output logic [AW:0]     cnt
);

   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic            set_ok;
   logic            clr_ok;
   logic            inc;
   logic            dec;
   logic [NREG-1:0] nxt;
   cnt_op_e         op;

   always_comb begin
      set_ok = is_on(set) && (set_addr != '0);
      clr_ok = is_on(clr) && (clr_addr != '0);
      inc    = set_ok && !busy[set_addr];
      // same-address clear is overridden by the new producer
      dec    = clr_ok && busy[clr_addr]
               && !(set_ok && (set_addr == clr_addr));
      op     = cnt_op_e'({inc, dec});
   end

   always_comb begin
      nxt = busy;
      if (clr_ok) nxt[clr_addr] = 1'b0;
      if (set_ok) nxt[set_addr] = 1'b1;
      nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= nxt;
         unique case (op)
            CNT_INC:  cnt <= cnt + ONE;
            CNT_DEC:  cnt <= cnt - ONE;
            CNT_HOLD: cnt <= cnt;
            CNT_BOTH: cnt <= cnt;
            default:  cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_22051013_regfile_sb.sv
// Integer register file with same-cycle write bypass and
// a scoreboard reporting operand hazards.
module ysyx_22051013_regfile_sb
   import ysyx_22051013_regfile_sb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input logic clk,
   input logic rst,
   ysyx_22051013_regfile_sb_if.slave bus
);

   localparam logic [XLEN-1:0] ZERO = ZERO64[XLEN-1:0];

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [AW:0]     cnt;
   logic            in_rst;
   logic            wr_ok;

   assign in_rst = (rst == RST_ACTIVE);
   assign wr_ok  = is_on(bus.wen) && (bus.waddr != '0);

   always_ff @(posedge clk) begin
      if (in_rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= ZERO;
      end else if (wr_ok) begin
         regs[bus.waddr] <= bus.wdata;
      end
   end

   always_comb begin
      bus.rdata1 = ZERO;
      if (in_rst || !is_on(bus.ren1) || bus.raddr1 == '0)
         bus.rdata1 = ZERO;
      else if (is_on(bus.wen) && bus.waddr == bus.raddr1)
         bus.rdata1 = bus.wdata;
      else
         bus.rdata1 = regs[bus.raddr1];
   end

   always_comb begin
      bus.rdata2 = ZERO;
      if (in_rst || !is_on(bus.ren2) || bus.raddr2 == '0)
         bus.rdata2 = ZERO;
      else if (is_on(bus.wen) && bus.waddr == bus.raddr2)
         bus.rdata2 = bus.wdata;
      else
         bus.rdata2 = regs[bus.raddr2];
   end

   // a writeback landing this cycle resolves the hazard early
   always_comb begin
      bus.hazard1 = 1'b0;
      bus.hazard2 = 1'b0;
      if (!in_rst && bus.raddr1 != '0)
         bus.hazard1 = is_on(bus.ren1) && busy[bus.raddr1]
            && !(is_on(bus.wen) && bus.waddr == bus.raddr1);
      if (!in_rst && bus.raddr2 != '0)
         bus.hazard2 = is_on(bus.ren2) && busy[bus.raddr2]
            && !(is_on(bus.wen) && bus.waddr == bus.raddr2);
   end

   ysyx_22051013_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set      (bus.busy_set),
      .set_addr (bus.busy_addr),
      .clr      (bus.wen),
      .clr_addr (bus.waddr),
      .busy     (busy),
      .cnt      (cnt)
   );

   assign bus.busy_vec = busy;
   assign bus.busy_cnt = cnt;

endmodule

// File: doc/ysyx_22051013_regfile_sb.md
YSYX_22051013_REGFILE_SB -- requirements
Module: ysyx_22051013_regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 64, register data width.
REQ-002 SHALL provide parameter NREG, default 32, register count (power of two, >=2).
REQ-003 SHALL provide derived parameter AW = log2(NREG), default 5, address width.
REQ-004 SHALL provide port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL provide port waddr  in  AW  writeback address.
REQ-007 SHALL provide port wdata  in  XLEN  writeback data.
REQ-008 SHALL provide port wen  in  1  writeback enable.
REQ-009 SHALL provide port raddr1/raddr2  in  AW  read addresses.
REQ-010 SHALL provide port ren1/ren2  in  1  read enables.
REQ-011 SHALL provide port rdata1/rdata2  out  XLEN  read data.
REQ-012 SHALL provide port busy_set  in  1  issue: mark busy_addr as pending destination.
REQ-013 SHALL provide port busy_addr  in  AW  destination being issued.
REQ-014 SHALL provide port hazard1/hazard2  out  1  operand n unavailable this cycle.
REQ-015 SHALL provide port busy_vec  out  NREG  per-register pending bits.
REQ-016 SHALL provide port busy_cnt  out  AW+1  number of set busy bits.

Function
REQ-017 SHALL hold register 0 at zero: writes to address 0 ignored, reads of address 0 return 0.
REQ-018 SHALL write wdata to regs[waddr] at the edge when wen=1 and waddr!=0.
REQ-019 SHALL drive rdataN combinationally: 0 if rst=1 or renN=0 or raddrN=0; else wdata if wen=1 and waddr==raddrN (same-cycle bypass); else regs[raddrN].
REQ-020 SHALL set busy[busy_addr] at the edge when busy_set=1 and busy_addr!=0.
REQ-021 SHALL clear busy[waddr] at the edge when wen=1 and waddr!=0.
REQ-022 SHALL, on busy_set and wen to the same nonzero address in one cycle, leave the bit set (new producer wins) while still writing wdata.
REQ-023 SHALL drive hazardN = renN & busy[raddrN] & ~(wen & waddr==raddrN), and 0 during rst or for raddrN=0.
REQ-024 SHALL keep busy_vec[0]=0 always.
REQ-025 SHALL maintain busy_cnt as a register equal to popcount(busy_vec) after every edge: +1 for set of a clear bit, -1 for clear of a set bit, net 0 when both occur on different addresses or set of an already-set bit.
REQ-026 SHALL never wrap busy_cnt; range 0..NREG-1.
REQ-027 SHALL permit two reads, one write and one busy_set per cycle with no structural stall.

Reset
REQ-028 SHALL, at an edge with rst=1, clear all registers, all busy bits and busy_cnt to 0, ignoring wen and busy_set that cycle.
REQ-029 SHALL drive rdata1/rdata2 and hazard1/hazard2 to 0 while rst=1; busy_vec and busy_cnt read 0 from the edge after rst is sampled.
REQ-030 SHALL abandon any pending (busy) registers on reset mid-operation; a later wen to a reset register writes normally and leaves busy_cnt at 0.

Structure
REQ-031 SHALL take XLEN/NREG defaults, the 64-bit zero constant and the reset/enable polarity constants from the shared define file.
REQ-032 SHALL place busy bits, set/clear priority and busy_cnt in one sub-module ysyx_22051013_scoreboard; data array and bypass stay in the top.

Verification
REQ-033 SHALL test reset: write x5=0xDEAD, assert rst one cycle -> read x5 = 0, busy_cnt = 0, rdata=0 during rst.
REQ-034 SHALL test x0: wen=1 waddr=0 wdata=0xFFFF_FFFF_FFFF_FFFF, busy_set addr 0 -> rdata1(x0)=0, busy_vec=0, hazard=0.
REQ-035 SHALL test bypass: regs[7]=1, same cycle wen x7=0x1234 and ren1 raddr1=7 -> rdata1=0x1234 combinationally; next cycle regs[7]=0x1234.
REQ-036 SHALL test scoreboard: busy_set x3 -> next cycle hazard1=1 on raddr1=3, busy_cnt=1; wen x3 -> hazard1=0 same cycle, busy_cnt=0 next.
REQ-037 SHALL test simultaneous: busy x4 set; same cycle wen x4 and busy_set x4 -> busy[4] stays 1, busy_cnt=1; busy_set x9 with wen x4 -> busy_cnt unchanged.
REQ-038 SHALL test fill: busy_set x1..x31 consecutively -> busy_cnt=31, busy_vec=0xFFFF_FFFE; rst -> all 0.
